dcdc_rail_sequencer: RTL and testbench

Parametrised multi-rail DC-DC enable sequencer in the always-on power controller of PD0. It drives NUM_RAILS rail enables from one level request. Power-up runs in ascending rail order and power-down in descending order, with a programmable per-rail, per-direction delay before each rail toggles. A direction change in the middle of a sequence reverses it from the current position, so rails are never left out of order.

---
 rtl/dcdc_rail_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_dcdc_rail_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcdc_rail_sequencer.sv
// -----------------------------------------------------------------------------
// dcdc_rail_sequencer
//
// Multi-rail DC-DC enable sequencer for the PD0 always-on power controller.
// One level request turns all rails on or off. Power-up enables rails in
// ascending order and power-down disables them in descending order. Before
// each rail toggles, a programmable per-rail, per-direction delay runs out.
// If the request changes in the middle of a sequence, the sequence reverses
// from the rail it has reached, so the enables always stay in order.
//
// Ports:
//   i_aon_clk         always-on clock
//   i_soc_pwr_on_rst  asynchronous, active-high reset (all rails on)
//   i_target_on       1 = all rails on, 0 = all rails off
//   i_on_dly          rail k power-on delay in [k*DLY_W +: DLY_W]
//   i_off_dly         rail k power-off delay, same packing
//   o_rail_en         rail enables, thermometer coded (rails 0..n_on-1 on)
//   o_all_on          all rails on and sequencer idle
//   o_all_off         all rails off and sequencer idle
//   o_busy            a sequence is in progress
//   o_seq_done        one-cycle pulse when a sequence completes
//
// State table:
//   state       | meaning
//   ST_ON       | all rails enabled, idle (n_on = NUM_RAILS)
//   ST_OFF      | all rails disabled, idle (n_on = 0)
//   ST_RAMP_UP  | enabling rail n_on once the counter reaches 0
//   ST_RAMP_DN  | disabling rail n_on-1 once the counter reaches 0
// -----------------------------------------------------------------------------
module dcdc_rail_sequencer #(
    parameter int NUM_RAILS = 4,
    parameter int DLY_W     = 8
) (
    input  logic                       i_aon_clk,
    input  logic                       i_soc_pwr_on_rst,
    input  logic                       i_target_on,
    input  logic [NUM_RAILS*DLY_W-1:0] i_on_dly,
    input  logic [NUM_RAILS*DLY_W-1:0] i_off_dly,
    output logic [NUM_RAILS-1:0]       o_rail_en,
    output logic                       o_all_on,
    output logic                       o_all_off,
    output logic                       o_busy,
    output logic                       o_seq_done
);

    localparam int              CW     = $clog2(NUM_RAILS + 1);
    localparam logic [CW-1:0]   N_FULL = CW'(NUM_RAILS);

    typedef enum logic [1:0] {
        ST_ON      = 2'd0,
        ST_OFF     = 2'd1,
        ST_RAMP_UP = 2'd2,
        ST_RAMP_DN = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      n_on, n_nxt;
    logic [DLY_W-1:0]   cnt, cnt_nxt;
    logic               done_nxt;

    // Saturating neighbours of n_on, so the index math can never wrap.
    logic [CW-1:0]      n_up, n_dn;

    // Delay field select. Out-of-range indices return 0 instead of
    // reading past the packed vector.
    function automatic logic [DLY_W-1:0] pick_dly(
        input logic [NUM_RAILS*DLY_W-1:0] vec,
        input logic [CW-1:0]              idx
    );
        logic [DLY_W-1:0] d;
        d = '0;
        for (int k = 0; k < NUM_RAILS; k++) begin
            if (idx == CW'(k)) begin
                d = vec[k*DLY_W +: DLY_W];
            end
        end
        return d;
    endfunction

    function automatic logic [NUM_RAILS-1:0] thermo(input logic [CW-1:0] n);
        logic [NUM_RAILS-1:0] t;
        t = '0;
        for (int k = 0; k < NUM_RAILS; k++) begin
            t[k] = (CW'(k) < n);
        end
        return t;
    endfunction

    assign n_up = (n_on < N_FULL) ? n_on + CW'(1) : N_FULL;
    assign n_dn = (n_on != '0)    ? n_on - CW'(1) : '0;

    always_comb begin
        state_nxt = state;
        n_nxt     = n_on;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;

        case (state)
            ST_ON: begin
                if (!i_target_on) begin
                    state_nxt = ST_RAMP_DN;
                    cnt_nxt   = pick_dly(i_off_dly, n_dn);
                end
            end

            ST_OFF: begin
                if (i_target_on) begin
                    state_nxt = ST_RAMP_UP;
                    cnt_nxt   = pick_dly(i_on_dly, n_on);
                end
            end

            ST_RAMP_UP: begin
                if (!i_target_on) begin
                    // Reversal wins over a pending toggle at this edge.
                    if (n_on == '0) begin
                        state_nxt = ST_OFF;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_RAMP_DN;
                        cnt_nxt   = pick_dly(i_off_dly, n_dn);
                    end
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - DLY_W'(1);
                end else begin
                    n_nxt = n_up;
                    if (n_up == N_FULL) begin
                        state_nxt = ST_ON;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = pick_dly(i_on_dly, n_up);
                    end
                end
            end

            ST_RAMP_DN: begin
                if (i_target_on) begin
                    if (n_on == N_FULL) begin
                        state_nxt = ST_ON;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_RAMP_UP;
                        cnt_nxt   = pick_dly(i_on_dly, n_on);
                    end
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - DLY_W'(1);
                end else begin
                    n_nxt = n_dn;
                    if (n_dn == '0) begin
                        state_nxt = ST_OFF;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = pick_dly(i_off_dly, n_dn - CW'(1));
                    end
                end
            end

            default: begin
                state_nxt = ST_ON;
                n_nxt     = N_FULL;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up
    // with the state register on the same edge.
    always_ff @(posedge i_aon_clk or posedge i_soc_pwr_on_rst) begin
        if (i_soc_pwr_on_rst) begin
            state      <= ST_ON;
            n_on       <= N_FULL;
            cnt        <= '0;
            o_rail_en  <= '1;
            o_all_on   <= 1'b1;
            o_all_off  <= 1'b0;
            o_busy     <= 1'b0;
            o_seq_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            n_on       <= n_nxt;
            cnt        <= cnt_nxt;
            o_rail_en  <= thermo(n_nxt);
            o_all_on   <= (state_nxt == ST_ON);
            o_all_off  <= (state_nxt == ST_OFF);
            o_busy     <= (state_nxt == ST_RAMP_UP) || (state_nxt == ST_RAMP_DN);
            o_seq_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_dcdc_rail_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dcdc_rail_sequencer
//
// Directed bench for dcdc_rail_sequencer. One 4-rail instance and one 1-rail
// instance share clock and reset. Inputs are driven 1 ns after the rising
// edge, so they are sampled at the next edge (called e0). Outputs are sampled
// 1 ns after each edge. Status is compared as a packed word
// {rail_en, busy, seq_done, all_on, all_off}.
// -----------------------------------------------------------------------------
module tb_dcdc_rail_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        target;
    logic [31:0] on_dly, off_dly;
    logic [3:0]  rail_en;
    logic        all_on, all_off, busy, seq_done;

    logic        target1;
    logic [7:0]  on1, off1;
    logic [0:0]  rail1;
    logic        all_on1, all_off1, busy1, done1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dcdc_rail_sequencer #(.NUM_RAILS(4), .DLY_W(8)) dut (
        .i_aon_clk        (clk),
        .i_soc_pwr_on_rst (rst),
        .i_target_on      (target),
        .i_on_dly         (on_dly),
        .i_off_dly        (off_dly),
        .o_rail_en        (rail_en),
        .o_all_on         (all_on),
        .o_all_off        (all_off),
        .o_busy           (busy),
        .o_seq_done       (seq_done)
    );

    dcdc_rail_sequencer #(.NUM_RAILS(1), .DLY_W(8)) dut1 (
        .i_aon_clk        (clk),
        .i_soc_pwr_on_rst (rst),
        .i_target_on      (target1),
        .i_on_dly         (on1),
        .i_off_dly        (off1),
        .o_rail_en        (rail1),
        .o_all_on         (all_on1),
        .o_all_off        (all_off1),
        .o_busy           (busy1),
        .o_seq_done       (done1)
    );

    wire [7:0] obs  = {rail_en, busy, seq_done, all_on, all_off};
    wire [4:0] obs1 = {rail1, busy1, done1, all_on1, all_off1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bring the 4-rail instance to an idle end state within a bounded time.
    task automatic settle(input logic want_on);
        int n;
        target = want_on;
        n = 0;
        while (!(want_on ? all_on : all_off) && n < 5000) begin
            tick();
            n++;
        end
        tick();
        tests++;
        if (!(want_on ? all_on : all_off)) begin
            fails++;
            $display("FAIL settle: all_on=%b all_off=%b, want_on=%b", all_on, all_off, want_on);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        tests++;
        if (obs !== 8'hF2) begin
            fails++;
            $display("FAIL reset_values: got %h want %h", obs, 8'hF2);
        end
        tests++;
        if (obs1 !== 5'h12) begin
            fails++;
            $display("FAIL reset_values_n1: got %h want %h", obs1, 5'h12);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        // Rail3 delay 1, others long: after e0..e0+3 only rail3 is off.
        off_dly = {8'd1, 8'd20, 8'd20, 8'd20};
        target  = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        tests++;
        if (obs !== 8'h78) begin
            fails++;
            $display("FAIL reset_pre_ramp: got %h want %h", obs, 8'h78);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (obs !== 8'hF2) begin
            fails++;
            $display("FAIL reset_async_mid_ramp: got %h want %h", obs, 8'hF2);
        end
        target = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tests++;
        if (obs !== 8'hF2) begin
            fails++;
            $display("FAIL on_hold: got %h want %h", obs, 8'hF2);
        end
    endtask

    task automatic test_power_down();
        logic [7:0] ex [9];
        ex = '{8'hF8, 8'hF8, 8'h78, 8'h38, 8'h38, 8'h38, 8'h18, 8'h05, 8'h01};
        off_dly = {8'd1, 8'd0, 8'd2, 8'd0};
        target  = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            tests++;
            if (obs !== ex[k]) begin
                fails++;
                $display("FAIL power_down e0+%0d: got %h want %h", k, obs, ex[k]);
            end
        end
    endtask

    task automatic test_power_up();
        logic [7:0] ex [12];
        ex = '{8'h08, 8'h08, 8'h08, 8'h18, 8'h38, 8'h38,
               8'h78, 8'h78, 8'h78, 8'h78, 8'hF6, 8'hF2};
        on_dly = {8'd3, 8'd1, 8'd0, 8'd2};
        target = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            tests++;
            if (obs !== ex[k]) begin
                fails++;
                $display("FAIL power_up e0+%0d: got %h want %h", k, obs, ex[k]);
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] ex [12];
        ex = '{8'h08, 8'h08, 8'h08, 8'h18, 8'h38, 8'h38,
               8'h38, 8'h38, 8'h18, 8'h18, 8'h05, 8'h01};
        settle(1'b0);
        on_dly  = {8'd3, 8'd1, 8'd0, 8'd2};
        off_dly = {8'd0, 8'd0, 8'd2, 8'd1};
        target  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            tests++;
            if (obs !== ex[k]) begin
                fails++;
                $display("FAIL abort e0+%0d: got %h want %h", k, obs, ex[k]);
            end
            if (k == 4) target = 1'b0;
        end
    endtask

    task automatic test_abort_collision();
        logic [7:0] ex [8];
        ex = '{8'h08, 8'h08, 8'h08, 8'h18, 8'h18, 8'h18, 8'h05, 8'h01};
        on_dly  = {8'd3, 8'd1, 8'd0, 8'd2};
        off_dly = {8'd0, 8'd0, 8'd2, 8'd1};
        target  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            tests++;
            if (obs !== ex[k]) begin
                fails++;
                $display("FAIL abort_collision e0+%0d: got %h want %h", k, obs, ex[k]);
            end
            if (k == 3) target = 1'b0;
        end
    endtask

    task automatic test_abort_at_target();
        logic [7:0] ex [6];
        ex = '{8'h08, 8'h05, 8'h01, 8'h01, 8'h01, 8'h01};
        on_dly = {8'd3, 8'd1, 8'd0, 8'd2};
        target = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            tests++;
            if (obs !== ex[k]) begin
                fails++;
                $display("FAIL abort_at_target e0+%0d: got %h want %h", k, obs, ex[k]);
            end
            if (k == 0) target = 1'b0;
        end
    endtask

    task automatic test_zero_delay();
        logic [7:0] ex_up [6];
        logic [7:0] ex_dn [6];
        ex_up = '{8'h08, 8'h18, 8'h38, 8'h78, 8'hF6, 8'hF2};
        ex_dn = '{8'hF8, 8'h78, 8'h38, 8'h18, 8'h05, 8'h01};
        on_dly  = '0;
        off_dly = '0;
        target  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            tests++;
            if (obs !== ex_up[k]) begin
                fails++;
                $display("FAIL zero_delay_up e0+%0d: got %h want %h", k, obs, ex_up[k]);
            end
        end
        target = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            tests++;
            if (obs !== ex_dn[k]) begin
                fails++;
                $display("FAIL zero_delay_dn e0+%0d: got %h want %h", k, obs, ex_dn[k]);
            end
        end
    endtask

    task automatic test_max_delay();
        logic [3:0] prev;
        int         chg[$];
        int         want[4];
        for (int dir = 0; dir < 2; dir++) begin
            chg.delete();
            on_dly  = '1;
            off_dly = '1;
            target  = (dir == 0);
            prev    = rail_en;
            for (int k = 0; k < 1030; k++) begin
                tick();
                if (rail_en !== prev) chg.push_back(k);
                prev = rail_en;
                if (k == 1024) begin
                    tests++;
                    if (seq_done !== 1'b1) begin
                        fails++;
                        $display("FAIL max_delay_done dir=%0d: got %b want 1", dir, seq_done);
                    end
                end
            end
            want = '{256, 512, 768, 1024};
            tests++;
            if (chg.size() != 4) begin
                fails++;
                $display("FAIL max_delay_count dir=%0d: got %0d want 4", dir, chg.size());
            end else begin
                for (int i = 0; i < 4; i++) begin
                    tests++;
                    if (chg[i] != want[i]) begin
                        fails++;
                        $display("FAIL max_delay_step dir=%0d i=%0d: got e0+%0d want e0+%0d",
                                 dir, i, chg[i], want[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_single_rail();
        logic [4:0] ex_dn [5];
        logic [4:0] ex_up [4];
        logic [4:0] ex_au [4];
        logic [4:0] ex_ad [3];
        ex_dn = '{5'h18, 5'h18, 5'h18, 5'h05, 5'h01};
        ex_up = '{5'h08, 5'h08, 5'h16, 5'h12};
        ex_au = '{5'h08, 5'h08, 5'h05, 5'h01};
        ex_ad = '{5'h18, 5'h16, 5'h12};

        off1    = 8'd2;
        target1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++;
            if (obs1 !== ex_dn[k]) begin
                fails++;
                $display("FAIL n1_down e0+%0d: got %h want %h", k, obs1, ex_dn[k]);
            end
        end

        on1     = 8'd1;
        target1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (obs1 !== ex_up[k]) begin
                fails++;
                $display("FAIL n1_up e0+%0d: got %h want %h", k, obs1, ex_up[k]);
            end
        end

        off1    = 8'd0;
        target1 = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        tests++;
        if (obs1 !== 5'h01) begin
            fails++;
            $display("FAIL n1_off_fast: got %h want %h", obs1, 5'h01);
        end

        on1     = 8'd3;
        target1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (obs1 !== ex_au[k]) begin
                fails++;
                $display("FAIL n1_abort_up e0+%0d: got %h want %h", k, obs1, ex_au[k]);
            end
            if (k == 1) target1 = 1'b0;
        end

        on1     = 8'd0;
        target1 = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        tests++;
        if (obs1 !== 5'h12) begin
            fails++;
            $display("FAIL n1_on_fast: got %h want %h", obs1, 5'h12);
        end

        off1    = 8'd3;
        target1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++;
            if (obs1 !== ex_ad[k]) begin
                fails++;
                $display("FAIL n1_abort_dn e0+%0d: got %h want %h", k, obs1, ex_ad[k]);
            end
            if (k == 0) target1 = 1'b1;
        end
    endtask

    initial begin
        target  = 1'b1;
        on_dly  = '0;
        off_dly = '0;
        target1 = 1'b1;
        on1     = '0;
        off1    = '0;
        #1;
        test_reset();
        test_power_down();
        test_power_up();
        test_abort();
        test_abort_collision();
        test_abort_at_target();
        test_zero_delay();
        settle(1'b0);
        test_max_delay();
        test_single_rail();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

endmodule
